ifetch: RTL and testbench

- Instruction fetch stage directly upstream of imem. Owns the program counter and drives imem's `iaddr`/`we`.
- imem has one-cycle synchronous read latency. ifetch captures the returned `idata` with its PC into a 2-entry output buffer.
- Presents instructions to decode over a valid/ready handshake. Supports stall (`en`, backpressure) and redirect (branch/jump).
- Replaces the VIO-driven `iaddr` in the imem test top.

---
 rtl/ifetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/ifetch.sv | 87 ++++++++
 tb/tb_ifetch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants for the instruction fetch stage.
//   IMEM_WIDTH   - word/address width of imem (PC, iaddr, idata, inst)
//   RESET_PC_DEF - PC loaded on reset
//   PC_STEP_DEF  - byte increment per issued fetch
//   FIFO_DEPTH   - entries in the fetch output buffer (fixed at 2)
package ifetch_pkg;
  localparam int          IMEM_WIDTH   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;
  localparam int          FIFO_DEPTH   = 2;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of {inst, pc} pairs.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (clears storage)
//   flush             - drop all entries at the next edge (storage kept)
//   push, push_inst, push_pc - write an entry
//   pop               - advance the head
//   count             - number of valid entries (0..2)
//   head_valid, head_inst, head_pc - registered head entry
// Handshake: an entry leaves when pop is high while head_valid is high;
// push and pop in one cycle keep the count and preserve order.
// Push into a full FIFO without a simultaneous pop is ignored.
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_inst,
  input  logic [W-1:0] push_pc,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         head_valid,
  output logic [W-1:0] head_inst,
  output logic [W-1:0] head_pc
);
  logic [W-1:0] inst_mem [2];
  logic [W-1:0] pc_mem   [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count_q;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop & (count_q != 2'd0);
  assign push_ok = push & ((count_q != 2'd2) | pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok) begin
        inst_mem[wr_ptr] <= push_inst;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_inst  = inst_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage in front of imem (1-cycle read latency).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   en                  - fetch enable (0 stops new requests, buffer drains)
//   redirect, redirect_pc - flush and restart fetching at redirect_pc
//   iaddr, we           - imem address (= pc) and write enable (always 0)
//   idata               - imem read data, valid the cycle after issue
//   inst_valid, inst_ready - output handshake to decode
//   inst, inst_pc       - instruction at buffer head and its PC
// Handshake: an instruction is transferred on any rising edge where
// inst_valid and inst_ready are both high; inst/inst_pc hold while
// inst_valid is high and inst_ready is low.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int          AW       = IMEM_WIDTH,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
  parameter logic [AW-1:0] PC_STEP  = AW'(PC_STEP_DEF),
  parameter int          DEPTH    = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] iaddr,
  output logic          we,
  input  logic [AW-1:0] idata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [AW-1:0] inst,
  output logic [AW-1:0] inst_pc
);
  logic [AW-1:0] pc;
  logic          inflight_q;
  logic [AW-1:0] inflight_pc;
  logic [1:0]    count;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    occupancy;

  assign pop = inst_valid & inst_ready;

  // Slots already claimed once this cycle's pop retires: buffered entries
  // plus the word returning from imem. A new fetch is only issued when its
  // data is guaranteed a slot, so the buffer can never overflow.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = en & ~redirect & (occupancy < 3'(DEPTH));

  // Returning data is dropped when a redirect lands in the same cycle.
  assign push = inflight_q & ~redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight_q  <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc         <= redirect_pc;
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc          <= pc + PC_STEP;
      inflight_q  <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fetch_fifo #(.W(AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_inst  (idata),
    .push_pc    (inflight_pc),
    .pop        (pop),
    .count      (count),
    .head_valid (inst_valid),
    .head_inst  (inst),
    .head_pc    (inst_pc)
  );

  assign iaddr = pc;
  assign we    = 1'b0;
endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] iaddr;
  logic          we;
  logic [AW-1:0] idata;
  logic          inst_valid;
  logic          inst_ready;
  logic [AW-1:0] inst;
  logic [AW-1:0] inst_pc;

  always #5 clk = ~clk;

  ifetch dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .iaddr       (iaddr),
    .we          (we),
    .idata       (idata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  // imem model: word at byte address 4i is 0x1000 + i, one-cycle latency.
  function automatic logic [AW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  always @(posedge clk) idata <= mem_word(iaddr);

  // ---------------- scoreboard ----------------
  int            total  = 0;
  int            passed = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_pc;
  int            pops;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  // Architectural reference: decode must see a gap-free PC sequence starting
  // at the reset / redirect target, each paired with its imem word.
  task automatic refill(input logic [AW-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(start + AW'(4 * i));
  endtask

  // Apply current inputs across one rising edge; outputs sampled 1ns later.
  task automatic tick();
    logic [AW-1:0] e;
    chk("we_zero", {31'b0, we}, '0);
    if (rst) begin
      refill(32'h0);
    end else begin
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        exp_q.push_back(exp_q[$] + 32'd4);
        chk("pop_pc", inst_pc, e);
        chk("pop_inst", inst, mem_word(e));
        pops++;
      end
      if (redirect) refill(redirect_pc);
    end
    exp_pc = exp_q[0];
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] held_inst, held_pc, held_addr;
    rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    refill(32'h0);
    @(posedge clk); #1;
    tick();
    // reset state
    chk("rst_valid", {31'b0, inst_valid}, '0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // 1: streaming from reset
    rst = 1'b0; en = 1'b1; inst_ready = 1'b1;
    tick();
    chk("s1_valid_e1", {31'b0, inst_valid}, '0);
    tick();
    chk("s1_valid_e2", {31'b0, inst_valid}, 32'h1);
    chk("s1_first_pc", inst_pc, 32'h0);
    chk("s1_first_inst", inst, 32'h1000);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s1_no_gap", {31'b0, inst_valid}, 32'h1);
    end

    // 2: backpressure for 5 cycles
    inst_ready = 1'b0;
    held_inst = inst; held_pc = inst_pc; held_addr = iaddr;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_hold_inst", inst, held_inst);
      chk("s2_hold_pc", inst_pc, held_pc);
      chk("s2_iaddr_frozen", iaddr, held_addr);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // 3: redirect with a full buffer
    inst_ready = 1'b0;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("s3_valid_r1", {31'b0, inst_valid}, '0);
    chk("s3_iaddr", iaddr, 32'h40);
    tick();
    chk("s3_valid_r2", {31'b0, inst_valid}, '0);
    tick();
    chk("s3_valid_r3", {31'b0, inst_valid}, 32'h1);
    chk("s3_first_pc", inst_pc, 32'h40);
    tick();
    chk("s3_second_pc", inst_pc, 32'h44);
    for (int i = 0; i < 3; i++) tick();

    // 4: en=0 drains, then resumes from held pc
    en = 1'b0;
    pops = 0;
    tick();
    held_addr = iaddr;
    for (int i = 0; i < 5; i++) tick();
    chk("s4_drained", {31'b0, inst_valid}, '0);
    chk("s4_drain_le3", 32'(pops <= 3), 32'h1);
    chk("s4_iaddr_held", iaddr, held_addr);
    chk("s4_iaddr_next", iaddr, exp_pc);
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // 5: reset mid-stream with a full buffer
    inst_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; inst_ready = 1'b1;
    chk("s5_valid", {31'b0, inst_valid}, '0);
    chk("s5_iaddr", iaddr, 32'h0);
    tick();
    chk("s5_valid_e1", {31'b0, inst_valid}, '0);
    tick();
    chk("s5_valid_e2", {31'b0, inst_valid}, 32'h1);
    chk("s5_first_pc", inst_pc, 32'h0);
    for (int i = 0; i < 3; i++) tick();

    // 6: wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("s6_iaddr_top", iaddr, 32'hFFFF_FFFC);
    tick();
    chk("s6_iaddr_wrap", iaddr, 32'h0);
    tick();
    chk("s6_pc_top", inst_pc, 32'hFFFF_FFFC);
    tick();
    chk("s6_pc_wrap", inst_pc, 32'h0);

    // random phase: order/data checked by the scoreboard in tick()
    for (int i = 0; i < 600; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom() & 32'hFFFF_FFFC;
      rst         = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; redirect = 1'b0; en = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("end_streaming", {31'b0, inst_valid}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
